// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with valid/ready handshake, flush, writeback select and forwarding tap.
// Define MEMWB_SKID_EN to add a skid entry so in_ready comes straight from flops.
module mem_wb_pipe #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] rdata_in,
  input  logic [DSIZE-1:0] aluresult_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             memtoreg_in,
  input  logic             wen_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] rdata_out,
  output logic [DSIZE-1:0] aluresult_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             memtoreg_out,
  output logic             wen_out,
  output logic [DSIZE-1:0] wb_data,
  output logic             wb_wen,
  output logic             fwd_valid,
  output logic [ASIZE-1:0] fwd_addr,
  output logic [DSIZE-1:0] fwd_data
);

  typedef struct packed {
    logic [DSIZE-1:0] rdata;
    logic [DSIZE-1:0] aluresult;
    logic [ASIZE-1:0] waddr;
    logic             memtoreg;
    logic             wen;
  } payload_t;

  payload_t in_p;
  payload_t main_q;
  logic     accept;
  logic     pop;

  assign in_p   = '{rdata: rdata_in, aluresult: aluresult_in, waddr: waddr_in,
                    memtoreg: memtoreg_in, wen: wen_in};
  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

`ifdef MEMWB_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t   state;
  payload_t skid_q;

  // Both ready and valid decode purely from state, so no path from out_ready to in_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      // NOTE: payload registers are reset as well so every output reads 0 out of reset,
      // even though the payload is a don't-care while invalid.
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      // NOTE: non-blocking assignments so each register samples pre-edge values,
      // which keeps the skid-to-main transfer order-independent.
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_p;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= in_p;
          end else if (pop) begin
            state <= EMPTY;
          end else if (accept) begin
            skid_q <= in_p;
            state  <= TWO;
          end
        end
        TWO: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
`else
  logic valid_q;

  // Without the skid entry a stalled full register must refuse input in the same cycle.
  assign in_ready  = out_ready | ~valid_q;
  assign out_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        main_q  <= in_p;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end
`endif

  assign rdata_out     = main_q.rdata;
  assign aluresult_out = main_q.aluresult;
  assign waddr_out     = main_q.waddr;
  assign memtoreg_out  = main_q.memtoreg;
  assign wen_out       = main_q.wen;

  // Register 0 is hardwired to zero, so writes to it are never requested or forwarded.
  assign wb_data   = main_q.memtoreg ? main_q.rdata : main_q.aluresult;
  assign wb_wen    = out_valid & main_q.wen & (main_q.waddr != '0);
  assign fwd_valid = wb_wen;
  assign fwd_addr  = main_q.waddr;
  assign fwd_data  = wb_data;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: queue-based reference model compared every cycle,
// plus directed literal checks for reset, streaming, stall, flush and writeback gating.
module tb_mem_wb_pipe;

`ifdef MEMWB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rdata_in;
  logic [31:0] aluresult_in;
  logic [4:0]  waddr_in;
  logic        memtoreg_in;
  logic        wen_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rdata_out;
  logic [31:0] aluresult_out;
  logic [4:0]  waddr_out;
  logic        memtoreg_out;
  logic        wen_out;
  logic [31:0] wb_data;
  logic        wb_wen;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;

  mem_wb_pipe #(.DSIZE(32), .ASIZE(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rdata_in(rdata_in), .aluresult_in(aluresult_in), .waddr_in(waddr_in),
    .memtoreg_in(memtoreg_in), .wen_in(wen_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .rdata_out(rdata_out), .aluresult_out(aluresult_out), .waddr_out(waddr_out),
    .memtoreg_out(memtoreg_out), .wen_out(wen_out),
    .wb_data(wb_data), .wb_wen(wb_wen),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  waddr;
    logic        m2r;
    logic        wen;
  } item_t;

  typedef struct {
    logic [31:0] wb;
    logic [31:0] alu;
    int          cyc;
  } seen_t;

  item_t q[$];
  seen_t seen[$];
  bit    zeroed;
  int    cyc;
  int    n_cmp;
  int    n_bad;

  bit    m_rdy;
  bit    m_acc;
  bit    m_pop;
  item_t m_new;
  item_t e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wa,
                       input logic m2r, input logic we);
    aluresult_in = alu;
    rdata_in     = rd;
    waddr_in     = wa;
    memtoreg_in  = m2r;
    wen_in       = we;
  endtask

  // Holds one transaction on the input until the DUT takes it, bounded by a cycle budget.
  task automatic send(input logic [31:0] alu);
    bit acc;
    int n;
    drive(alu, $urandom, 5'($urandom_range(1, 31)), 1'b0, 1'b1);
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = in_ready && !flush;
      n++;
      step();
    end
    in_valid = 1'b0;
    check("send_accepted", acc, 1);
  endtask

  // Reference model: an ordered queue of held entries, capacity 2 with the skid, 1 without.
  initial begin
    cyc = 0;
    zeroed = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        zeroed = 1'b1;
      end else if (flush) begin
        q.delete();
      end else begin
        m_rdy = SKID ? (q.size() < 2) : (out_ready || q.size() == 0);
        m_acc = in_valid && m_rdy;
        m_pop = (q.size() > 0) && out_ready;
        m_new = '{rdata: rdata_in, alu: aluresult_in, waddr: waddr_in,
                  m2r: memtoreg_in, wen: wen_in};
        if (m_pop) void'(q.pop_front());
        if (m_acc) begin
          q.push_back(m_new);
          zeroed = 1'b0;
        end
      end

      @(negedge clk);
      check("in_ready", in_ready, SKID ? (q.size() < 2) : (out_ready || q.size() == 0));
      check("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        e = q[0];
        check("rdata_out", rdata_out, e.rdata);
        check("aluresult_out", aluresult_out, e.alu);
        check("waddr_out", waddr_out, e.waddr);
        check("memtoreg_out", memtoreg_out, e.m2r);
        check("wen_out", wen_out, e.wen);
        check("wb_data", wb_data, e.m2r ? e.rdata : e.alu);
        check("wb_wen", wb_wen, e.wen && (e.waddr != 0));
        check("fwd_valid", fwd_valid, e.wen && (e.waddr != 0));
        check("fwd_addr", fwd_addr, e.waddr);
        check("fwd_data", fwd_data, e.m2r ? e.rdata : e.alu);
      end else begin
        check("idle_wb_wen", wb_wen, 0);
        check("idle_fwd_valid", fwd_valid, 0);
        if (zeroed) begin
          check("zero_rdata", rdata_out, 0);
          check("zero_alu", aluresult_out, 0);
          check("zero_waddr", waddr_out, 0);
          check("zero_ctl", {memtoreg_out, wen_out}, 0);
          check("zero_wb_data", wb_data, 0);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1)
        seen.push_back('{wb: wb_data, alu: aluresult_out, cyc: cyc});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Reset held 3 cycles with a live-looking input.
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(32'hDEADBEEF, 32'hDEADBEEF, 5'd7, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_rdata_out", rdata_out, 0);
    check("rst_alu_out", aluresult_out, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_wen", wb_wen, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    step();
    rst = 1'b0;
    drive(32'h55, 32'h66, 5'd4, 1'b0, 1'b1);
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("first_latency_valid", out_valid, 1);
    check("first_latency_wb_data", wb_data, 32'h55);
    repeat (3) step();

    // Streaming: 8 back-to-back, no bubbles.
    seen.delete();
    for (int i = 0; i < 8; i++) send(32'h10 + 32'(i));
    repeat (3) step();
    check("stream_count", seen.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen.size()) begin
        check("stream_wb_data", seen[i].wb, 32'h10 + 32'(i));
        if (i > 0) check("stream_no_bubble", seen[i].cyc - seen[i-1].cyc, 1);
      end
    end

    // Stall for 4 cycles mid-stream.
    seen.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) send(32'h20 + 32'(i));
      end
      begin
        repeat (3) step();
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready_first", in_ready, SKID ? 1 : 0);
        step();
        @(negedge clk);
        check("stall_in_ready_next", in_ready, 0);
        check("stall_depth", q.size(), SKID ? 2 : 1);
        repeat (3) step();
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    check("stall_count", seen.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < seen.size()) check("stall_order", seen[i].alu, 32'h20 + 32'(i));

    // Flush while full with a concurrent input.
    seen.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(32'hF0, $urandom, 5'd2, 1'b0, 1'b1);
    step();
    drive(32'hF1, $urandom, 5'd3, 1'b0, 1'b1);
    step();
    flush = 1'b1;
    drive(32'hF2, $urandom, 5'd4, 1'b0, 1'b1);
    @(negedge clk);
    check("flush_pre_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_wb_wen", wb_wen, 0);
    repeat (4) step();
    check("flush_none_retired", seen.size(), 0);

    // Writeback select and register-0 gating.
    in_valid = 1'b1;
    drive(32'h1234, 32'hCAFE0001, 5'd3, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("sel_rdata_wb_data", wb_data, 32'hCAFE0001);
    check("sel_rdata_wb_wen", wb_wen, 1);
    check("sel_rdata_fwd_addr", fwd_addr, 3);
    step();
    in_valid = 1'b1;
    drive(32'h4321, 32'hCAFE0002, 5'd0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("r0_wb_data", wb_data, 32'h4321);
    check("r0_wb_wen", wb_wen, 0);
    check("r0_fwd_valid", fwd_valid, 0);
    repeat (2) step();

    // Randomized traffic with occasional flush and reset.
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      drive($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Reset and flush together: reset wins and zeroes the payload.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(32'h77, 32'h88, 5'd9, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("rf_pre_valid", out_valid, 1);
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rf_out_valid", out_valid, 0);
    check("rf_alu_out", aluresult_out, 0);
    check("rf_rdata_out", rdata_out, 0);
    check("rf_wb_data", wb_data, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
